// File: rtl/go_stop_conditioner.sv
// go_stop_conditioner: turns the raw, bouncy go/stop operator buttons into
// clean single-cycle command pulses for the run/pause control FSM.
// Each button is synchronised (two flops), debounced and rising-edge detected.
// When both commands appear in the same cycle, stop wins and the dropped go
// is recorded in a sticky conflict flag.
//
// Ports:
//   clk            rising-edge clock
//   rst            asynchronous active-high reset
//   go_raw         raw go button, asynchronous to clk
//   stop_raw       raw stop button, asynchronous to clk
//   clear_conflict synchronous clear of the conflict flag
//   go             single-cycle go command pulse (registered)
//   stop           single-cycle stop command pulse (registered)
//   go_level       debounced go level (registered)
//   stop_level     debounced stop level (registered)
//   conflict       sticky: a go pulse was dropped in favour of stop

// One debounce channel: synchroniser, debounce FSM and press detection.
// pulse_c is combinational and marks the cycle before the level rises.
module go_stop_channel #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic pulse_c,
    output logic level
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ARMING    = 2'd1,
        PRESSED   = 2'd2,
        RELEASING = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nx;
    logic             level_nx;
    logic             s1;
    logic             s2;

    // Two-flop synchroniser; only s2 is used downstream.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= raw;
            s2 <= s1;
        end
    end

    // State, counter and debounced level registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            level <= 1'b0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            level <= level_nx;
        end
    end

    // Debounce next-state logic; a change is accepted after DEBOUNCE_CYCLES
    // consecutive samples at the new level.
    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        level_nx = level;
        pulse_c  = 1'b0;
        case (state)
            IDLE: begin
                if (s2) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = ARMING;
                end else begin
                    cnt_nx = '0;
                end
            end
            ARMING: begin
                if (!s2) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = PRESSED;
                    level_nx = 1'b1;
                    pulse_c  = 1'b1;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            PRESSED: begin
                if (!s2) begin
                    cnt_nx   = CNT_ONE;
                    state_nx = RELEASING;
                end
            end
            RELEASING: begin
                if (s2) begin
                    cnt_nx   = '0;
                    state_nx = PRESSED;
                end else if (cnt == CNT_LAST) begin
                    cnt_nx   = '0;
                    state_nx = IDLE;
                    level_nx = 1'b0;
                end else begin
                    cnt_nx = cnt + CNT_ONE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = IDLE;
            end
        endcase
    end

endmodule

module go_stop_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned CNT_W           = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic go_raw,
    input  logic stop_raw,
    input  logic clear_conflict,
    output logic go,
    output logic stop,
    output logic go_level,
    output logic stop_level,
    output logic conflict
);

    logic go_pulse_c;
    logic stop_pulse_c;

    go_stop_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_go_ch (
        .clk    (clk),
        .rst    (rst),
        .raw    (go_raw),
        .pulse_c(go_pulse_c),
        .level  (go_level)
    );

    go_stop_channel #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
        .CNT_W          (CNT_W)
    ) u_stop_ch (
        .clk    (clk),
        .rst    (rst),
        .raw    (stop_raw),
        .pulse_c(stop_pulse_c),
        .level  (stop_level)
    );

    // Command arbitration: stop wins a tie; a set event beats a clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            go       <= 1'b0;
            stop     <= 1'b0;
            conflict <= 1'b0;
        end else begin
            go   <= go_pulse_c & ~stop_pulse_c;
            stop <= stop_pulse_c;
            if (go_pulse_c && stop_pulse_c) begin
                conflict <= 1'b1;
            end else if (clear_conflict) begin
                conflict <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_go_stop_conditioner.sv
// Self-checking bench for go_stop_conditioner (DEBOUNCE_CYCLES = 4).
// A window-based model predicts every output each cycle; directed scenarios
// pin the model with hand-computed pulse timings.
module tb_go_stop_conditioner;

    localparam int unsigned D = 4;

    logic clk = 1'b0;
    logic rst;
    logic go_raw;
    logic stop_raw;
    logic clear_conflict;
    logic go;
    logic stop;
    logic go_level;
    logic stop_level;
    logic conflict;

    int n_checks = 0;
    int n_fail   = 0;

    go_stop_conditioner #(
        .DEBOUNCE_CYCLES(D),
        .CNT_W          (3)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .go_raw        (go_raw),
        .stop_raw      (stop_raw),
        .clear_conflict(clear_conflict),
        .go            (go),
        .stop          (stop),
        .go_level      (go_level),
        .stop_level    (stop_level),
        .conflict      (conflict)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: a level flips once the last D synchronised samples
    // all disagree with it; a 0->1 flip is a press command.
    logic [1:0]   m_s1;
    logic [1:0]   m_s2;
    logic [1:0]   lvl;
    logic [D-1:0] win0;
    logic [D-1:0] win1;
    logic [1:0]   flip;
    logic [1:0]   rise;
    logic         exp_go;
    logic         exp_stop;
    logic         exp_conf;

    assign flip[0] = ({win0[D-2:0], m_s2[0]} == {D{~lvl[0]}});
    assign flip[1] = ({win1[D-2:0], m_s2[1]} == {D{~lvl[1]}});
    assign rise    = flip & ~lvl;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_s1     <= '0;
            m_s2     <= '0;
            lvl      <= '0;
            win0     <= '0;
            win1     <= '0;
            exp_go   <= 1'b0;
            exp_stop <= 1'b0;
            exp_conf <= 1'b0;
        end else begin
            m_s1     <= {stop_raw, go_raw};
            m_s2     <= m_s1;
            win0     <= {win0[D-2:0], m_s2[0]};
            win1     <= {win1[D-2:0], m_s2[1]};
            lvl      <= lvl ^ flip;
            exp_go   <= rise[0] & ~rise[1];
            exp_stop <= rise[1];
            exp_conf <= (rise[0] & rise[1]) | (exp_conf & ~clear_conflict);
        end
    end

    // Per-cycle comparison against the model, plus pulse-width rule.
    logic prev_go   = 1'b0;
    logic prev_stop = 1'b0;
    always @(negedge clk) begin
        check("go", go, exp_go);
        check("stop", stop, exp_stop);
        check("go_level", go_level, lvl[0]);
        check("stop_level", stop_level, lvl[1]);
        check("conflict", conflict, exp_conf);
        check("go_width", prev_go & go, 0);
        check("stop_width", prev_stop & stop, 0);
        prev_go   = go;
        prev_stop = stop;
    end

    // Drive bit k-1 of the patterns before edge k; record pulse edges.
    int first_go, n_go, first_stop, n_stop, fall_go;
    task automatic run_pat(input logic [63:0] gp, input logic [63:0] sp, input int n);
        logic pl;
        pl         = go_level;
        first_go   = 0;
        n_go       = 0;
        first_stop = 0;
        n_stop     = 0;
        fall_go    = 0;
        for (int k = 1; k <= n; k++) begin
            go_raw   = gp[k-1];
            stop_raw = sp[k-1];
            @(posedge clk);
            #1;
            if (go) begin
                n_go++;
                if (first_go == 0) first_go = k;
            end
            if (stop) begin
                n_stop++;
                if (first_stop == 0) first_stop = k;
            end
            if (pl && !go_level && fall_go == 0) fall_go = k;
            pl = go_level;
        end
    endtask

    localparam logic [63:0] ONES  = ~64'd0;
    localparam logic [63:0] ZEROS = 64'd0;

    logic [63:0] p;
    int          total_go;

    initial begin
        rst            = 1'b1;
        go_raw         = 1'b0;
        stop_raw       = 1'b0;
        clear_conflict = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_go", go, 0);
        check("rst_stop", stop, 0);
        check("rst_conflict", conflict, 0);
        rst = 1'b0;

        // Clean press, then release.
        run_pat(ONES, ZEROS, 20);
        check("clean_first_go", first_go, 6);
        check("clean_n_go", n_go, 1);
        check("clean_n_stop", n_stop, 0);
        check("clean_level", go_level, 1);
        run_pat(ZEROS, ZEROS, 12);
        check("clean_release_fall", fall_go, 6);

        // Glitch of 3 samples is rejected.
        run_pat(64'h7, ZEROS, 12);
        check("glitch_n_go", n_go, 0);
        check("glitch_level", go_level, 0);

        // Press bounce 1,0,1,1,... : pulse 5 edges after last rising sample.
        p    = ONES;
        p[1] = 1'b0;
        run_pat(p, ZEROS, 14);
        check("bounce_first_go", first_go, 8);
        check("bounce_n_go", n_go, 1);
        run_pat(ZEROS, ZEROS, 12);

        // Hold 50, release 10, press again.
        run_pat((64'd1 << 50) - 64'd1, ZEROS, 60);
        total_go = n_go;
        check("hold_fall", fall_go, 56);
        run_pat(ONES, ZEROS, 20);
        total_go += n_go;
        check("repress_total", total_go, 2);
        // Release bounce 0,1,0 then held: no pulse, no level drop.
        p    = ONES;
        p[0] = 1'b0;
        p[2] = 1'b0;
        run_pat(p, ZEROS, 20);
        check("relbounce_n_go", n_go, 0);
        check("relbounce_fall", fall_go, 0);
        run_pat(ZEROS, ZEROS, 12);

        // Simultaneous commands: stop wins, conflict latches.
        run_pat(ONES, ONES, 12);
        check("sim_first_stop", first_stop, 6);
        check("sim_n_stop", n_stop, 1);
        check("sim_n_go", n_go, 0);
        check("sim_conflict", conflict, 1);
        run_pat(ZEROS, ZEROS, 12);
        check("sim_conflict_held", conflict, 1);
        clear_conflict = 1'b1;
        run_pat(ZEROS, ZEROS, 1);
        clear_conflict = 1'b0;
        check("clear_conflict", conflict, 0);
        // Clear coinciding with a new conflict: set wins.
        run_pat(ONES, ONES, 5);
        clear_conflict = 1'b1;
        run_pat(ONES, ONES, 1);
        clear_conflict = 1'b0;
        check("coinc_stop_edge", first_stop, 1);
        check("coinc_conflict", conflict, 1);
        run_pat(ZEROS, ZEROS, 12);
        clear_conflict = 1'b1;
        run_pat(ZEROS, ZEROS, 1);
        clear_conflict = 1'b0;

        // Offset commands: stop one cycle after go.
        run_pat(ONES, ONES << 1, 12);
        check("offset_first_go", first_go, 6);
        check("offset_first_stop", first_stop, 7);
        check("offset_conflict", conflict, 0);
        run_pat(ZEROS, ZEROS, 12);

        // Reset mid-arming with stop held and conflict set.
        run_pat(ONES, ONES, 12);
        run_pat(ZEROS, ONES, 12);
        run_pat(ONES, ONES, 3);
        #2;
        rst      = 1'b1;
        stop_raw = 1'b0;
        #1;
        check("arst_go", go, 0);
        check("arst_stop_level", stop_level, 0);
        check("arst_go_level", go_level, 0);
        check("arst_conflict", conflict, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        run_pat(ONES, ZEROS, 12);
        check("arst_first_go", first_go, 6);
        check("arst_n_go", n_go, 1);
        run_pat(ZEROS, ZEROS, 12);

        // Randomised bouncy stimulus, checked by the per-cycle model.
        for (int c = 0; c < 1500; ) begin
            int hold;
            hold           = $urandom_range(1, 12);
            go_raw         = 1'($urandom_range(0, 1));
            stop_raw       = 1'($urandom_range(0, 1));
            for (int h = 0; h < hold; h++) begin
                clear_conflict = ($urandom_range(0, 7) == 0);
                @(posedge clk);
                #1;
            end
            c += hold;
        end
        clear_conflict = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
